rv_multicycle_ctrl: RTL

- Multi-cycle control FSM for the RV32 core datapath. Generalised successor of the single-cycle opcode decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Handshakes with instruction/data memory (req/ready) and with the iterative mul/div unit (start/done).
- Raises traps for illegal opcodes and memory timeouts.
- Sits between the instruction register and the PC, regfile, ALU and memory muxes.

---
 rtl/rv_pkg.sv | 53 +++++
 rtl/rv_alu_dec.sv | 37 +++
 rtl/rv_multicycle_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32 multi-cycle controller: opcodes, ALU ops,
// mux selects, trap causes and the controller state set.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_ALU   = 2'b01;
    localparam logic [1:0] PC_TRAP  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_MD  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MD_WAIT, S_WB, S_TRAP
    } state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// Combinational ALU function select from opcode/funct3/funct7[5].
// Zero latency; no flow control.
module rv_alu_dec
    import rv_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    output logic [ALU_OP_W-1:0] alu_op
);

    logic [3:0] op;

    always_comb begin
        op = ALU_ADD;
        if (opcode == OP_BRANCH) begin
            op = ALU_SUB;
        end else if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                // ADDI has no subtract form; funct7[5] there is immediate data
                3'b000: op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: op = ALU_SLL;
                3'b010: op = ALU_SLT;
                3'b011: op = ALU_SLTU;
                3'b100: op = ALU_XOR;
                3'b101: op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110: op = ALU_OR;
                3'b111: op = ALU_AND;
            endcase
        end
    end

    assign alu_op = ALU_OP_W'(op);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB plus MD_WAIT and TRAP.
// Holds mem_req until mem_ready (optional timeout trap); waits on md_done.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int HAS_M       = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                md_done,
    input  logic                br_taken,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_b,
    output logic                md_start,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     wait_cnt, wait_cnt_nx;
    logic [1:0]           cause_q, cause_nx;
    logic [ALU_OP_W-1:0]  dec_alu_op;
    logic [6:0]           opcode;
    logic                 is_load, is_store, is_branch, is_jump, is_rtype, is_muldiv;
    logic                 legal, timeout;
    logic                 unused_instr_bits;

    assign opcode    = instr[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_rtype  = (opcode == OP_R);
    assign is_muldiv = is_rtype && (instr[31:25] == F7_MULDIV);
    assign legal     = is_legal_op(opcode);
    assign unused_instr_bits = ^instr[24:15];

    // mem_ready in the deadline cycle still completes the access
    assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

    rv_alu_dec #(.ALU_OP_W(ALU_OP_W)) u_alu_dec (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_op   (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            cause_q  <= cause_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cause_nx   = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_PLUS4;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        alu_op     = '0;
        alu_src_b  = 1'b0;
        md_start   = 1'b0;
        trap       = 1'b0;
        trap_cause = cause_q;

        case (state)
            S_FETCH: begin
                mem_req = !timeout;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!legal || (is_muldiv && HAS_M == 0)) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else if (is_muldiv) begin
                    md_start = 1'b1;
                    state_nx = S_MD_WAIT;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op    = dec_alu_op;
                alu_src_b = !(is_rtype || is_branch);
                if (is_load || is_store) begin
                    state_nx = S_MEM;
                end else if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = br_taken ? PC_ALU : PC_PLUS4;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = !timeout;
                mem_we   = is_store && !timeout;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_MD_WAIT: begin
                if (md_done) state_nx = S_WB;
            end
            S_WB: begin
                reg_write = (instr[11:7] != 5'd0);
                if (is_load)        wb_sel = WB_MEM;
                else if (is_jump)   wb_sel = WB_PC4;
                else if (is_muldiv) wb_sel = WB_MD;
                pc_write = 1'b1;
                pc_sel   = is_jump ? PC_ALU : PC_PLUS4;
                state_nx = S_FETCH;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_sel   = PC_TRAP;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase

        // Wait counter only runs while a memory phase keeps waiting
        if ((state == S_FETCH || state == S_MEM) && state_nx == state)
            wait_cnt_nx = wait_cnt + 1'b1;
        else
            wait_cnt_nx = '0;

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_sel     = PC_PLUS4;
            reg_write  = 1'b0;
            wb_sel     = WB_ALU;
            alu_op     = '0;
            alu_src_b  = 1'b0;
            md_start   = 1'b0;
            trap       = 1'b0;
            trap_cause = CAUSE_NONE;
        end
    end

endmodule
